ghr_spec_dual: RTL

Parametrised, dual-slot speculative global history register with checkpointed misprediction recovery. Sits between the fetch-stage predictor, which consumes `ghr_spec` for index hashing, and branch resolution in execute. It shifts up to two predicted branch outcomes per cycle into a speculative history. Each branch's pre-shift history is saved in a circular checkpoint buffer. An in-order architectural history is kept alongside, and the speculative history is repaired in one cycle on a mispredict.

---
 rtl/ghr_spec_dual.sv | 100 ++++++++++
 1 files changed

// File: rtl/ghr_spec_dual.sv
// ghr_spec_dual: dual-slot speculative global history register.
// Up to two predicted branches per cycle shift into ghr_spec. Each branch's
// pre-shift history is saved in a circular checkpoint buffer. ghr_arch tracks
// resolved outcomes in order. A mispredict repairs ghr_spec in one cycle from
// the head checkpoint.
module ghr_spec_dual #(
  parameter int HIST_W = 6,
  parameter int DEPTH  = 8,
  parameter int TAG_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        fetch_br,
  input  logic [1:0]        fetch_pred,
  output logic              fetch_ready,
  output logic [TAG_W-1:0]  fetch_tag0,
  output logic [TAG_W-1:0]  fetch_tag1,
  input  logic              resolve_valid,
  input  logic              resolve_taken,
  input  logic              resolve_mispred,
  output logic [HIST_W-1:0] ghr_spec,
  output logic [HIST_W-1:0] ghr_arch,
  output logic [TAG_W:0]    ckpt_count,
  output logic              err
);

  localparam int CNT_W = TAG_W + 1;

  logic [HIST_W-1:0] ckpt [DEPTH];
  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;

  logic              resolve_ok;
  logic              mispred;
  logic              push_ok;
  logic [1:0]        push_n;
  logic [HIST_W-1:0] hist_mid;
  logic [HIST_W-1:0] hist_new;
  logic [CNT_W-1:0]  count_next;
  logic              err_set;

  // Ready is judged on registered occupancy only; same-cycle resolves do not help.
  assign fetch_ready = (ckpt_count <= CNT_W'(DEPTH - 2));
  assign fetch_tag0  = tail;
  assign fetch_tag1  = fetch_br[0] ? tail + TAG_W'(1) : tail;

  // Decode this cycle's actions and the history after each slot's shift.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    hist_mid   = ghr_spec;
    hist_new   = ghr_spec;
    push_n     = {1'b0, fetch_br[0]} + {1'b0, fetch_br[1]};
    resolve_ok = resolve_valid && (ckpt_count != '0);
    mispred    = resolve_ok && resolve_mispred;
    push_ok    = (fetch_br != 2'b00) && fetch_ready && !mispred;
    err_set    = (resolve_valid && (ckpt_count == '0)) ||
                 ((fetch_br != 2'b00) && !fetch_ready && !mispred);
    if (fetch_br[0]) hist_mid = {ghr_spec[HIST_W-2:0], fetch_pred[0]};
    hist_new = hist_mid;
    if (fetch_br[1]) hist_new = {hist_mid[HIST_W-2:0], fetch_pred[1]};
    count_next = ckpt_count + (push_ok ? CNT_W'(push_n) : CNT_W'(0))
                            - CNT_W'(resolve_ok);
  end

  // Checkpoint storage: slot 0 saves the pre-shift history, slot 1 the mid history.
  always_ff @(posedge clock) begin
    // NOTE: the checkpoint array has no reset; entries are only read after being written.
    if (push_ok && fetch_br[0]) ckpt[fetch_tag0] <= ghr_spec;
    if (push_ok && fetch_br[1]) ckpt[fetch_tag1] <= hist_mid;
  end

  // Pointers, histories, occupancy and the sticky error flag.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      ghr_spec   <= '0;
      ghr_arch   <= '0;
      head       <= '0;
      tail       <= '0;
      ckpt_count <= '0;
      err        <= 1'b0;
    end else begin
      if (mispred) begin
        // Repair from the head checkpoint; the head read is the old entry.
        ghr_spec <= {ckpt[head][HIST_W-2:0], resolve_taken};
        tail     <= head + TAG_W'(1);
      end else if (push_ok) begin
        ghr_spec <= hist_new;
        tail     <= tail + TAG_W'(push_n);
      end
      if (resolve_ok) begin
        ghr_arch <= {ghr_arch[HIST_W-2:0], resolve_taken};
        head     <= head + TAG_W'(1);
      end
      ckpt_count <= mispred ? '0 : count_next;
      if (err_set) err <= 1'b1;
    end
  end

endmodule
